count_seq_monitor: RTL

- Downstream consumer of the free-running 4-bit up-counter.
- Samples the counter's `count` output every clock and checks that it advances by exactly +1 (mod 2^WIDTH).
- Acquires and loses lock with hysteresis.
- Reports wrap events and sequence errors as single-cycle pulses and as saturating event counters, for status logging and bench self-checking.

---
 rtl/count_seq_monitor.sv | 113 +++++++++++
 1 files changed

// File: rtl/count_seq_monitor.sv
// Sequence monitor for a free-running up-counter: checks +1 steps, locks with
// hysteresis, and reports wraps and sequence errors as pulses and saturating counts.
module count_seq_monitor #(
    parameter int WIDTH     = 4,
    parameter int CNT_W     = 8,
    parameter int LOCK_LEN  = 4,
    parameter int ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] count_in,
    output logic             locked,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } state_t;

    localparam logic [3:0]       LOCK_TGT = 4'(LOCK_LEN);
    localparam logic [3:0]       ERR_TGT  = 4'(ERR_LIMIT);
    localparam logic [WIDTH-1:0] MAX_VAL  = '1;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       good_run;
    logic [3:0]       bad_run;

    logic good;
    logic wrap_evt;
    logic err_evt;

    // A hold or an early return to zero is bad; only max->0 counts as a wrap.
    assign good     = (count_in == prev + WIDTH'(1));
    assign wrap_evt = en && (state == LOCKED) && good && (prev == MAX_VAL) && (count_in == '0);
    assign err_evt  = en && (state == LOCKED) && !good;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            good_run   <= '0;
            bad_run    <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            wrap_pulse <= wrap_evt;
            err_pulse  <= err_evt;
            if (!en) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                prev <= count_in;
                unique case (state)
                    IDLE: begin
                        state    <= SYNC;
                        good_run <= '0;
                    end
                    SYNC: begin
                        if (good) begin
                            good_run <= good_run + 4'd1;
                            if (good_run + 4'd1 == LOCK_TGT) begin
                                state   <= LOCKED;
                                bad_run <= '0;
                                locked  <= 1'b1;
                            end
                        end else begin
                            good_run <= '0;
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            bad_run <= '0;
                        end else begin
                            bad_run <= bad_run + 4'd1;
                            if (bad_run + 4'd1 == ERR_TGT) begin
                                state    <= SYNC;
                                good_run <= '0;
                                locked   <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Clear beats a coincident increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wrap_count <= '0;
            err_count  <= '0;
        end else begin
            if (wrap_evt && (wrap_count != '1))
                wrap_count <= wrap_count + CNT_W'(1);
            if (err_evt && (err_count != '1))
                err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
